// File: rtl/serializer_pkg.sv
// Shared definitions for the serializer: FSM state encoding and the
// shortest word length the block will transmit.
package serializer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    localparam int SER_MIN_LEN = 3;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter. Loads a WIDTH-bit word on a strobe and shifts
// the selected number of bits out MSB-first with a per-bit valid. All outputs
// are flops; busy_o is low in the final output cycle so words can be streamed
// back-to-back without a gap.
// Optional feature: define SERIALIZER_PARITY_EN to append one even-parity bit
// after the data bits of every word.
module serializer #(
    parameter int WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [$clog2(WIDTH)-1:0] data_mod_i,
    input  logic                     data_val_i,
    output logic                     ser_data_o,
    output logic                     ser_data_val_o,
    output logic                     busy_o
);
    import serializer_pkg::*;

    localparam int MOD_W = $clog2(WIDTH);
    localparam int CNT_W = MOD_W + 1;

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ser_data_q, ser_data_d;
    logic             ser_val_q, ser_val_d;
    logic             busy_q, busy_d;
`ifdef SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
    logic             par_phase_q, par_phase_d;
`endif

    logic             len_ok;
    logic             load;
    logic [CNT_W-1:0] load_len;

    // Decode the requested length and decide whether a strobe is taken this cycle
    always_comb begin
        len_ok   = (data_mod_i == '0) ||
                   ({1'b0, data_mod_i} >= CNT_W'(SER_MIN_LEN));
        load     = data_val_i && !busy_q && len_ok;
        load_len = (data_mod_i == '0) ? CNT_W'(WIDTH) : {1'b0, data_mod_i};
    end

    // Next-state logic: cnt_q holds the bits still to send after the one on the output
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ser_data_d = 1'b0;
        ser_val_d  = 1'b0;
        busy_d     = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        parity_d    = parity_q;
        par_phase_d = par_phase_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d    = SEND;
                    ser_data_d = data_i[WIDTH-1];
                    ser_val_d  = 1'b1;
                    shift_d    = data_i << 1;
                    cnt_d      = load_len - CNT_W'(1);
                    busy_d     = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                    parity_d    = data_i[WIDTH-1];
                    par_phase_d = 1'b0;
`endif
                end
            end

            SEND: begin
                if (cnt_q != '0) begin
                    ser_data_d = shift_q[WIDTH-1];
                    ser_val_d  = 1'b1;
                    shift_d    = shift_q << 1;
                    cnt_d      = cnt_q - CNT_W'(1);
`ifdef SERIALIZER_PARITY_EN
                    parity_d   = parity_q ^ shift_q[WIDTH-1];
                    busy_d     = 1'b1;
`else
                    busy_d     = (cnt_q != CNT_W'(1));
`endif
                end
`ifdef SERIALIZER_PARITY_EN
                else if (!par_phase_q) begin
                    ser_data_d  = parity_q;
                    ser_val_d   = 1'b1;
                    par_phase_d = 1'b1;
                    busy_d      = 1'b0;
                end
`endif
                else if (load) begin
                    state_d    = SEND;
                    ser_data_d = data_i[WIDTH-1];
                    ser_val_d  = 1'b1;
                    shift_d    = data_i << 1;
                    cnt_d      = load_len - CNT_W'(1);
                    busy_d     = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                    parity_d    = data_i[WIDTH-1];
                    par_phase_d = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any word in flight
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            ser_data_q <= 1'b0;
            ser_val_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_q    <= 1'b0;
            par_phase_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ser_data_q <= ser_data_d;
            ser_val_q  <= ser_val_d;
            busy_q     <= busy_d;
`ifdef SERIALIZER_PARITY_EN
            parity_q    <= parity_d;
            par_phase_q <= par_phase_d;
`endif
        end
    end

    assign ser_data_o     = ser_data_q;
    assign ser_data_val_o = ser_val_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_serializer.sv
// Directed testbench for the serializer (WIDTH = 16). Collects the serial
// stream, regroups it into words the way the downstream deserializer would,
// and compares against hand-computed values. Honours SERIALIZER_PARITY_EN.
module tb_serializer;

    logic        clk;
    logic        arst;
    logic [15:0] data;
    logic [3:0]  dataMod;
    logic        dataVal;
    logic        serData;
    logic        serVal;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;

    logic [127:0] stream;
    logic [127:0] busyStream;
    int           n;
    logic         timedOut;
    int           validSeen;

    serializer #(.WIDTH(16)) dut (
        .clk_i          (clk),
        .arst_i         (arst),
        .data_i         (data),
        .data_mod_i     (dataMod),
        .data_val_i     (dataVal),
        .ser_data_o     (serData),
        .ser_data_val_o (serVal),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Present a one-cycle strobe; on return the first bit (if any) is on the outputs
    task automatic applyStimulus(input logic [15:0] word, input logic [3:0] mode);
        data    = word;
        dataMod = mode;
        dataVal = 1'b1;
        tick();
        dataVal = 1'b0;
    endtask

    // Record contiguous valid cycles. injectMode 1 strobes injWord in the final
    // output cycle (busy low); injectMode 2 strobes it at cycle index injAt.
    task automatic collectStream(input int maxCycles, input int injectMode,
                                 input int injAt, input logic [15:0] injWord,
                                 output logic [127:0] bits, output logic [127:0] busyBits,
                                 output int count, output logic expired);
        logic injected;
        injected = 1'b0;
        bits     = '0;
        busyBits = '0;
        count    = 0;
        expired  = 1'b1;
        for (int c = 0; c < maxCycles; c++) begin
            if (!serVal) begin
                expired = 1'b0;
                break;
            end
            bits     = {bits[126:0], serData};
            busyBits = {busyBits[126:0], busy};
            count++;
            if (!injected && ((injectMode == 1 && !busy) || (injectMode == 2 && c == injAt))) begin
                data     = injWord;
                dataMod  = 4'd0;
                dataVal  = 1'b1;
                injected = 1'b1;
            end
            tick();
            dataVal = 1'b0;
        end
    endtask

    task automatic countValid(input int cycles, output int seen);
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            if (serVal) seen++;
            tick();
        end
    endtask

    initial begin
        arst    = 1'b1;
        data    = '0;
        dataMod = '0;
        dataVal = 1'b0;
        tick();
        tick();
        checkOutput("reset ser_data", 128'(serData), 128'd0);
        checkOutput("reset ser_val", 128'(serVal), 128'd0);
        checkOutput("reset busy", 128'(busy), 128'd0);
        arst = 1'b0;
        tick();
        checkOutput("idle ser_val", 128'(serVal), 128'd0);

        // Full-width word
        applyStimulus(16'hA5C3, 4'd0);
        collectStream(40, 0, 0, 16'h0, stream, busyStream, n, timedOut);
        checkOutput("full timeout", 128'(timedOut), 128'd0);
`ifdef SERIALIZER_PARITY_EN
        checkOutput("full count", 128'(n), 128'd17);
        checkOutput("full bits", stream, 128'h1_4B86);
        checkOutput("full busy", busyStream, 128'h1_FFFE);
`else
        checkOutput("full count", 128'(n), 128'd16);
        checkOutput("full bits", stream, 128'hA5C3);
        checkOutput("full busy", busyStream, 128'hFFFE);
`endif
        checkOutput("full idle busy", 128'(busy), 128'd0);
        checkOutput("full idle data", 128'(serData), 128'd0);

        // Short word, 5 bits
        applyStimulus(16'hF800, 4'd5);
        collectStream(40, 0, 0, 16'h0, stream, busyStream, n, timedOut);
        checkOutput("len5 timeout", 128'(timedOut), 128'd0);
`ifdef SERIALIZER_PARITY_EN
        checkOutput("len5 count", 128'(n), 128'd6);
        checkOutput("len5 bits", stream, 128'h3F);
        checkOutput("len5 busy", busyStream, 128'h3E);
`else
        checkOutput("len5 count", 128'(n), 128'd5);
        checkOutput("len5 bits", stream, 128'h1F);
        checkOutput("len5 busy", busyStream, 128'h1E);
`endif

        // Illegal lengths 2 and 1
        applyStimulus(16'hFFFF, 4'd2);
        checkOutput("mod2 busy", 128'(busy), 128'd0);
        countValid(20, validSeen);
        checkOutput("mod2 no output", 128'(validSeen), 128'd0);
        applyStimulus(16'hFFFF, 4'd1);
        checkOutput("mod1 busy", 128'(busy), 128'd0);
        countValid(20, validSeen);
        checkOutput("mod1 no output", 128'(validSeen), 128'd0);

        // Back-to-back words with the second strobe in the final output cycle
        applyStimulus(16'h8001, 4'd0);
        collectStream(80, 1, 0, 16'h7FFE, stream, busyStream, n, timedOut);
        checkOutput("b2b timeout", 128'(timedOut), 128'd0);
`ifdef SERIALIZER_PARITY_EN
        checkOutput("b2b count", 128'(n), 128'd34);
        checkOutput("b2b word1", 128'(stream[33:18]), 128'h8001);
        checkOutput("b2b par1", 128'(stream[17]), 128'd0);
        checkOutput("b2b word2", 128'(stream[16:1]), 128'h7FFE);
        checkOutput("b2b par2", 128'(stream[0]), 128'd0);
`else
        checkOutput("b2b count", 128'(n), 128'd32);
        checkOutput("b2b word1", 128'(stream[31:16]), 128'h8001);
        checkOutput("b2b word2", 128'(stream[15:0]), 128'h7FFE);
`endif

        // Strobe while busy is ignored
        applyStimulus(16'h0000, 4'd0);
        collectStream(40, 2, 3, 16'hFFFF, stream, busyStream, n, timedOut);
        checkOutput("busy strobe timeout", 128'(timedOut), 128'd0);
`ifdef SERIALIZER_PARITY_EN
        checkOutput("busy strobe count", 128'(n), 128'd17);
`else
        checkOutput("busy strobe count", 128'(n), 128'd16);
`endif
        checkOutput("busy strobe bits", stream, 128'd0);
        countValid(30, validSeen);
        checkOutput("busy strobe no resend", 128'(validSeen), 128'd0);

        // Reset during bit 7
        applyStimulus(16'hFFFF, 4'd0);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("midreset pre val", 128'(serVal), 128'd1);
        arst = 1'b1;
        #1;
        checkOutput("midreset data", 128'(serData), 128'd0);
        checkOutput("midreset val", 128'(serVal), 128'd0);
        checkOutput("midreset busy", 128'(busy), 128'd0);
        tick();
        arst = 1'b0;
        countValid(30, validSeen);
        checkOutput("midreset no resume", 128'(validSeen), 128'd0);

        // Word with odd parity content
        applyStimulus(16'h0007, 4'd0);
        collectStream(40, 0, 0, 16'h0, stream, busyStream, n, timedOut);
        checkOutput("par timeout", 128'(timedOut), 128'd0);
`ifdef SERIALIZER_PARITY_EN
        checkOutput("par count", 128'(n), 128'd17);
        checkOutput("par bits", stream, 128'h0000F);
`else
        checkOutput("par count", 128'(n), 128'd16);
        checkOutput("par bits", stream, 128'h0007);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
